// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - shared types and helpers for the LSU-to-RAM master
//
// Contents:
//   size_e      access size encoding on size_i (3 is illegal)
//   state_e     master FSM states
//   WORD_BYTES  bytes per RAM word
//   size_bytes  access size -> byte count (1/2/4)

package lsu_pkg;

    localparam int WORD_BYTES = 4;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2
    } size_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SPLIT = 2'd1,
        RESP  = 2'd2,
        RESP2 = 2'd3
    } state_e;

    // Illegal size 3 maps to 4 bytes; such requests are rejected before
    // any RAM access, so the value only has to be harmless.
    function automatic logic [2:0] size_bytes(input logic [1:0] sz);
        logic [2:0] n;
        case (sz)
            SZ_BYTE: n = 3'd1;
            SZ_HALF: n = 3'd2;
            default: n = 3'd4;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// rtl/lsu_align.sv - byte-lane alignment for stores and merge/extend for loads
//
// Ports:
//   off_i, size_i, wdata_i      store side: byte offset, size, LSB-justified data
//   mask_o                      8-bit byte mask over two words ([3:0] beat 1, [7:4] beat 2)
//   wdata_lo_o, wdata_hi_o      store data rotated into beat 1 / beat 2 lanes
//   rd_off_i, rd_size_i         load side: latched offset and size
//   rd_sign_i                   sign-extend the load result
//   rd_lo_i, rd_hi_i            first and second read words ({hi, lo} is shifted)
//   rdata_o                     extracted, extended load data

module lsu_align
    import lsu_pkg::*;
(
    input  logic [1:0]  off_i,
    input  logic [1:0]  size_i,
    input  logic [31:0] wdata_i,
    output logic [7:0]  mask_o,
    output logic [31:0] wdata_lo_o,
    output logic [31:0] wdata_hi_o,
    input  logic [1:0]  rd_off_i,
    input  logic [1:0]  rd_size_i,
    input  logic        rd_sign_i,
    input  logic [31:0] rd_lo_i,
    input  logic [31:0] rd_hi_i,
    output logic [31:0] rdata_o
);

    logic [7:0]  ones;
    logic [63:0] wshift;
    logic [31:0] rsel;

    always_comb begin
        case (size_i)
            SZ_BYTE: ones = 8'h01;
            SZ_HALF: ones = 8'h03;
            default: ones = 8'h0F;
        endcase
        mask_o = ones << off_i;

        // Shifting across a 64-bit window yields both beats at once; the
        // upper half is the spill-over into the following word.
        wshift     = {32'd0, wdata_i} << {off_i, 3'b000};
        wdata_lo_o = wshift[31:0];
        wdata_hi_o = wshift[63:32];

        rsel = 32'({rd_hi_i, rd_lo_i} >> {rd_off_i, 3'b000});
        case (rd_size_i)
            SZ_BYTE: rdata_o = {{24{rd_sign_i & rsel[7]}}, rsel[7:0]};
            SZ_HALF: rdata_o = {{16{rd_sign_i & rsel[15]}}, rsel[15:0]};
            default: rdata_o = rsel;
        endcase
    end

endmodule

// File: rtl/lsu_ram_master.sv
// rtl/lsu_ram_master.sv - core LSU request/response adapter for a byte-enabled single-port RAM
//
// Ports:
//   clk, rst                    clock, asynchronous active-high reset
//   req_i, we_i, size_i,        core request: valid, store, size,
//   sign_ext_i, addr_i, wdata_i   sign-extend, byte address, LSB-justified data
//   gnt_o                       request accepted this cycle (combinational)
//   rvalid_o, rdata_o, err_o    one response per granted request
//   ram_en_o, ram_we_o,         RAM command: enable, write enable,
//   ram_be_o, ram_addr_o,         byte enables, word-aligned byte address,
//   ram_wdata_o                   lane-rotated write data
//   ram_rdata_i                 RAM read data, one cycle after ram_en_o

module lsu_ram_master
    import lsu_pkg::*;
#(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_i,
    input  logic                  we_i,
    input  logic [1:0]            size_i,
    input  logic                  sign_ext_i,
    input  logic [31:0]           addr_i,
    input  logic [31:0]           wdata_i,
    output logic                  gnt_o,
    output logic                  rvalid_o,
    output logic [31:0]           rdata_o,
    output logic                  err_o,
    output logic                  ram_en_o,
    output logic                  ram_we_o,
    output logic [3:0]            ram_be_o,
    output logic [ADDR_WIDTH-1:0] ram_addr_o,
    output logic [31:0]           ram_wdata_o,
    input  logic [31:0]           ram_rdata_i
);

    if (DATA_WIDTH != 32) begin : g_width_check
        $error("lsu_ram_master: only DATA_WIDTH = 32 is supported");
    end

    state_e                state_q;
    logic [1:0]            off_q;
    logic [1:0]            size_q;
    logic                  sign_q;
    logic                  we_q;
    logic                  err_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [31:0]           wdata_hi_q;
    logic [3:0]            be_hi_q;
    logic [31:0]           lo_q;

    logic [2:0]            req_n;
    logic                  req_mis;
    logic                  req_oob;
    logic                  req_wrap;
    logic                  req_err;
    logic [ADDR_WIDTH-1:0] req_aligned;
    logic                  accept;

    logic [7:0]            mask;
    logic [31:0]           wdata_lo;
    logic [31:0]           wdata_hi;
    logic [31:0]           rd_lo;
    logic [31:0]           rd_hi;
    logic [31:0]           rdata_merged;

    // Request decode on the live inputs.
    always_comb begin
        req_n       = size_bytes(size_i);
        req_mis     = ({2'b00, addr_i[1:0]} + {1'b0, req_n}) > 4'd4;
        req_aligned = {addr_i[ADDR_WIDTH-1:2], 2'b00};
        req_oob     = (addr_i >> ADDR_WIDTH) != 32'd0;
        // aligned + 4 overflows the RAM exactly when every word-index bit is set.
        req_wrap    = req_mis & (&req_aligned[ADDR_WIDTH-1:2]);
        req_err     = req_oob | (size_i == 2'd3) | req_wrap;
        // The RAM port is busy only with the second beat of a split.
        accept      = req_i & ~rst & (state_q != SPLIT);
    end

    // Second read word is live RAM data only in RESP2; the first word of a
    // split was captured into lo_q during SPLIT.
    always_comb begin
        if (state_q == RESP2) begin
            rd_lo = lo_q;
            rd_hi = ram_rdata_i;
        end else begin
            rd_lo = ram_rdata_i;
            rd_hi = 32'd0;
        end
    end

    lsu_align u_align (
        .off_i      (addr_i[1:0]),
        .size_i     (size_i),
        .wdata_i    (wdata_i),
        .mask_o     (mask),
        .wdata_lo_o (wdata_lo),
        .wdata_hi_o (wdata_hi),
        .rd_off_i   (off_q),
        .rd_size_i  (size_q),
        .rd_sign_i  (sign_q),
        .rd_lo_i    (rd_lo),
        .rd_hi_i    (rd_hi),
        .rdata_o    (rdata_merged)
    );

    // RAM command and core response. Reset forces everything low at once,
    // including the paths that are combinational from the request inputs.
    always_comb begin
        gnt_o       = accept;
        ram_en_o    = 1'b0;
        ram_we_o    = 1'b0;
        ram_be_o    = 4'd0;
        ram_addr_o  = '0;
        ram_wdata_o = 32'd0;

        if (!rst) begin
            if (state_q == SPLIT) begin
                ram_en_o    = 1'b1;
                ram_we_o    = we_q;
                ram_be_o    = be_hi_q;
                ram_addr_o  = addr_q + ADDR_WIDTH'(WORD_BYTES);
                ram_wdata_o = wdata_hi_q;
            end else if (accept && !req_err) begin
                ram_en_o    = 1'b1;
                ram_we_o    = we_i;
                ram_be_o    = mask[3:0];
                ram_addr_o  = req_aligned;
                ram_wdata_o = wdata_lo;
            end
        end

        rvalid_o = ~rst & ((state_q == RESP) | (state_q == RESP2));
        err_o    = rvalid_o & err_q;
        rdata_o  = (rvalid_o && !we_q && !err_q) ? rdata_merged : 32'd0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            off_q      <= 2'd0;
            size_q     <= 2'd0;
            sign_q     <= 1'b0;
            we_q       <= 1'b0;
            err_q      <= 1'b0;
            addr_q     <= '0;
            wdata_hi_q <= 32'd0;
            be_hi_q    <= 4'd0;
            lo_q       <= 32'd0;
        end else begin
            case (state_q)
                SPLIT: begin
                    lo_q    <= ram_rdata_i;
                    state_q <= RESP2;
                end
                default: begin
                    if (accept) begin
                        off_q      <= addr_i[1:0];
                        size_q     <= size_i;
                        sign_q     <= sign_ext_i;
                        we_q       <= we_i;
                        err_q      <= req_err;
                        addr_q     <= req_aligned;
                        wdata_hi_q <= wdata_hi;
                        be_hi_q    <= mask[7:4];
                        state_q    <= (req_mis && !req_err) ? SPLIT : RESP;
                    end else begin
                        state_q <= IDLE;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_ram_master.sv
// tb/tb_lsu_ram_master.sv - directed self-checking bench for lsu_ram_master

module tb_lsu_ram_master;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_i, we_i, sign_ext_i;
    logic [1:0]  size_i;
    logic [31:0] addr_i, wdata_i;
    logic        gnt_o, rvalid_o, err_o;
    logic [31:0] rdata_o;
    logic        ram_en_o, ram_we_o;
    logic [3:0]  ram_be_o;
    logic [15:0] ram_addr_o;
    logic [31:0] ram_wdata_o;
    logic [31:0] ram_rdata_i = 32'd0;

    int total = 0;
    int bad   = 0;

    logic [31:0] mem [0:16383];

    always #5 clk = ~clk;

    lsu_ram_master #(.ADDR_WIDTH(16), .DATA_WIDTH(32)) dut (
        .clk         (clk),
        .rst         (rst),
        .req_i       (req_i),
        .we_i        (we_i),
        .size_i      (size_i),
        .sign_ext_i  (sign_ext_i),
        .addr_i      (addr_i),
        .wdata_i     (wdata_i),
        .gnt_o       (gnt_o),
        .rvalid_o    (rvalid_o),
        .rdata_o     (rdata_o),
        .err_o       (err_o),
        .ram_en_o    (ram_en_o),
        .ram_we_o    (ram_we_o),
        .ram_be_o    (ram_be_o),
        .ram_addr_o  (ram_addr_o),
        .ram_wdata_o (ram_wdata_o),
        .ram_rdata_i (ram_rdata_i)
    );

    function automatic logic [31:0] be_bits(input logic [3:0] be);
        return {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
    endfunction

    // Byte-enabled RAM with one-cycle registered read.
    always @(posedge clk) begin
        if (ram_en_o) begin
            if (ram_we_o)
                mem[ram_addr_o[15:2]] <= (mem[ram_addr_o[15:2]] & ~be_bits(ram_be_o))
                                       | (ram_wdata_o & be_bits(ram_be_o));
            else
                ram_rdata_i <= mem[ram_addr_o[15:2]];
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic r, input logic w, input logic [1:0] sz,
                         input logic sx, input logic [31:0] a, input logic [31:0] wd);
        req_i = r; we_i = w; size_i = sz; sign_ext_i = sx; addr_i = a; wdata_i = wd;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Aligned load: grant and beat in cycle 0, response in cycle 1.
    task automatic load1(input string tag, input logic [31:0] a, input logic [1:0] sz,
                         input logic sx, input logic [3:0] exp_be, input logic [31:0] exp);
        drive(1'b1, 1'b0, sz, sx, a, 32'd0);
        @(negedge clk);
        chk({tag, "_gnt"}, 32'(gnt_o), 32'h1);
        chk({tag, "_en"}, 32'(ram_en_o), 32'h1);
        chk({tag, "_addr"}, 32'(ram_addr_o), a & 32'hFFFC);
        chk({tag, "_be"}, 32'(ram_be_o), 32'(exp_be));
        step();
        drive(1'b0, 1'b0, 2'd0, 1'b0, 32'd0, 32'd0);
        @(negedge clk);
        chk({tag, "_rvalid"}, 32'(rvalid_o), 32'h1);
        chk({tag, "_rdata"}, rdata_o, exp);
        chk({tag, "_err"}, 32'(err_o), 32'h0);
        step();
    endtask

    // Rejected request: granted, no RAM access, error response next cycle.
    task automatic err1(input string tag, input logic [1:0] sz, input logic [31:0] a);
        drive(1'b1, 1'b0, sz, 1'b0, a, 32'd0);
        @(negedge clk);
        chk({tag, "_gnt"}, 32'(gnt_o), 32'h1);
        chk({tag, "_en"}, 32'(ram_en_o), 32'h0);
        step();
        drive(1'b0, 1'b0, 2'd0, 1'b0, 32'd0, 32'd0);
        @(negedge clk);
        chk({tag, "_rvalid"}, 32'(rvalid_o), 32'h1);
        chk({tag, "_err"}, 32'(err_o), 32'h1);
        chk({tag, "_rdata"}, rdata_o, 32'h0);
        step();
    endtask

    initial begin
        mem[32'h10 >> 2] = 32'h88776655;
        mem[32'h14 >> 2] = 32'hCCBBAA99;

        // Reset with a request pending: nothing may leak out.
        rst = 1'b1;
        drive(1'b1, 1'b0, 2'd2, 1'b0, 32'h10, 32'd0);
        @(negedge clk);
        chk("rst_gnt", 32'(gnt_o), 32'h0);
        chk("rst_en", 32'(ram_en_o), 32'h0);
        chk("rst_rvalid", 32'(rvalid_o), 32'h0);
        chk("rst_err", 32'(err_o), 32'h0);
        chk("rst_rdata", rdata_o, 32'h0);
        step();
        rst = 1'b0;
        drive(1'b0, 1'b0, 2'd0, 1'b0, 32'd0, 32'd0);
        step();

        load1("lw10", 32'h10, 2'd2, 1'b0, 4'hF, 32'h88776655);
        load1("lb13s", 32'h13, 2'd0, 1'b1, 4'h8, 32'hFFFFFF88);
        load1("lbu13", 32'h13, 2'd0, 1'b0, 4'h8, 32'h00000088);
        load1("lh12s", 32'h12, 2'd1, 1'b1, 4'hC, 32'hFFFF8877);

        // Misaligned LW 0x12, with LW 0x14 held during SPLIT and granted in RESP2.
        drive(1'b1, 1'b0, 2'd2, 1'b0, 32'h12, 32'd0);
        @(negedge clk);
        chk("mis_c0_gnt", 32'(gnt_o), 32'h1);
        chk("mis_c0_addr", 32'(ram_addr_o), 32'h10);
        chk("mis_c0_be", 32'(ram_be_o), 32'hC);
        step();
        drive(1'b1, 1'b0, 2'd2, 1'b0, 32'h14, 32'd0);
        @(negedge clk);
        chk("mis_c1_gnt", 32'(gnt_o), 32'h0);
        chk("mis_c1_en", 32'(ram_en_o), 32'h1);
        chk("mis_c1_addr", 32'(ram_addr_o), 32'h14);
        chk("mis_c1_be", 32'(ram_be_o), 32'h3);
        chk("mis_c1_rvalid", 32'(rvalid_o), 32'h0);
        step();
        @(negedge clk);
        chk("mis_c2_rvalid", 32'(rvalid_o), 32'h1);
        chk("mis_c2_rdata", rdata_o, 32'hAA998877);
        chk("held_gnt", 32'(gnt_o), 32'h1);
        chk("held_addr", 32'(ram_addr_o), 32'h14);
        chk("held_be", 32'(ram_be_o), 32'hF);
        step();
        drive(1'b0, 1'b0, 2'd0, 1'b0, 32'd0, 32'd0);
        @(negedge clk);
        chk("held_rvalid", 32'(rvalid_o), 32'h1);
        chk("held_rdata", rdata_o, 32'hCCBBAA99);
        step();

        // Reset asserted mid-split: RAM beat and response vanish immediately.
        drive(1'b1, 1'b0, 2'd2, 1'b0, 32'h12, 32'd0);
        step();
        drive(1'b0, 1'b0, 2'd0, 1'b0, 32'd0, 32'd0);
        #1;
        rst = 1'b1;
        #1;
        chk("rsplit_en", 32'(ram_en_o), 32'h0);
        chk("rsplit_be", 32'(ram_be_o), 32'h0);
        chk("rsplit_addr", 32'(ram_addr_o), 32'h0);
        step();
        rst = 1'b0;
        @(negedge clk);
        chk("rsplit_norvalid", 32'(rvalid_o), 32'h0);
        step();
        load1("post_rst_lw10", 32'h10, 2'd2, 1'b0, 4'hF, 32'h88776655);

        // Misaligned SH 0x13.
        drive(1'b1, 1'b1, 2'd1, 1'b0, 32'h13, 32'h0000BEEF);
        @(negedge clk);
        chk("sh_c0_gnt", 32'(gnt_o), 32'h1);
        chk("sh_c0_we", 32'(ram_we_o), 32'h1);
        chk("sh_c0_addr", 32'(ram_addr_o), 32'h10);
        chk("sh_c0_be", 32'(ram_be_o), 32'h8);
        chk("sh_c0_wdata", ram_wdata_o, 32'hEF000000);
        step();
        drive(1'b0, 1'b0, 2'd0, 1'b0, 32'd0, 32'd0);
        @(negedge clk);
        chk("sh_c1_en", 32'(ram_en_o), 32'h1);
        chk("sh_c1_we", 32'(ram_we_o), 32'h1);
        chk("sh_c1_addr", 32'(ram_addr_o), 32'h14);
        chk("sh_c1_be", 32'(ram_be_o), 32'h1);
        chk("sh_c1_wdata", ram_wdata_o, 32'h000000BE);
        step();
        @(negedge clk);
        chk("sh_rvalid", 32'(rvalid_o), 32'h1);
        chk("sh_rdata", rdata_o, 32'h0);
        chk("sh_err", 32'(err_o), 32'h0);
        step();

        // Back-to-back aligned loads with req held.
        drive(1'b1, 1'b0, 2'd2, 1'b0, 32'h10, 32'd0);
        @(negedge clk);
        chk("b2b_c0_gnt", 32'(gnt_o), 32'h1);
        step();
        drive(1'b1, 1'b0, 2'd2, 1'b0, 32'h14, 32'd0);
        @(negedge clk);
        chk("b2b_c1_gnt", 32'(gnt_o), 32'h1);
        chk("b2b_c1_addr", 32'(ram_addr_o), 32'h14);
        chk("b2b_c1_rvalid", 32'(rvalid_o), 32'h1);
        chk("b2b_c1_rdata", rdata_o, 32'hEF776655);
        step();
        drive(1'b0, 1'b0, 2'd0, 1'b0, 32'd0, 32'd0);
        @(negedge clk);
        chk("b2b_c2_rvalid", 32'(rvalid_o), 32'h1);
        chk("b2b_c2_rdata", rdata_o, 32'hCCBBAABE);
        step();

        err1("err_oob", 2'd2, 32'h0001_0000);
        err1("err_wrap", 2'd2, 32'h0000_FFFE);
        err1("err_size", 2'd3, 32'h0000_0010);

        @(negedge clk);
        chk("idle_rvalid", 32'(rvalid_o), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
